fp_add_arbiter: RTL

//  Shares one pipelined FP16 adder (sign/5b exp/10b frac) among NREQ requesters (neuron update units).

---
 rtl/fp_add_arbiter_pkg.sv | 10 +
 rtl/fp_add_arbiter_rr_pick.sv | 33 +++
 rtl/fp_add_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_pkg.sv
// Shared FP16 constants and sizing defaults for the adder arbiter and its users.
package fp_add_arbiter_pkg;

    localparam int          FP16_W   = 16;
    localparam int          NREQ_DEF = 4;
    localparam int          TAG_W    = $clog2(NREQ_DEF);
    localparam logic [15:0] FP16_ONE = 16'h3C00;
    localparam logic [15:0] FP16_TWO = 16'h4000;

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant for the first request at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic         found;
    logic [W-1:0] j;

    always_comb begin
        // NOTE: every output of this block gets a default up front so no path leaves one unassigned (no latch).
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        // NOTE: blocking assignments here so 'found' and 'j' update within the same loop pass.
        for (int k = 0; k < N; k++) begin
            j = W'((int'(ptr) + k) % N);
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency FP16 adder among NREQ requesters; tags each issue and routes results back in order.
module fp_add_arbiter
    import fp_add_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [FP16_W*NREQ-1:0] req_a,
    input  logic [FP16_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [FP16_W-1:0]      rsp_data,
    output logic [FP16_W-1:0]      add_a,
    output logic [FP16_W-1:0]      add_b,
    output logic                   add_en,
    input  logic [FP16_W-1:0]      add_out,
    input  logic                   add_ready,
    output logic                   busy,
    output logic                   err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
    logic             pick_en;
    logic             push;
    logic             pop;

    // Grants use the registered count, so a pop in the same cycle never frees a slot early.
    assign pick_en = !rst && (count < CNT_W'(TAG_DEPTH));
    assign push    = |(req & gnt);
    assign pop     = add_ready && (count != '0);
    assign busy    = add_en || (count != '0) || (rsp_valid != '0);

    rr_pick #(.N(NREQ), .W(IDX_W)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .en  (pick_en),
        .gnt (gnt),
        .idx (win)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            add_en <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
        end else begin
            add_en <= push;
            if (push) begin
                add_a  <= req_a[win*FP16_W +: FP16_W];
                add_b  <= req_b[win*FP16_W +: FP16_W];
                rr_ptr <= (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after being written, guarded by count.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= pop ? (NREQ'(1) << tag_mem[rd_ptr]) : '0;
            if (pop) rsp_data <= add_out;
            if (add_ready && (count == '0)) err <= 1'b1;
        end
    end

endmodule
